// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: Cause field positions, ExcCode values, helpers.
package cp0_pkg;

  // Cause register (Reg 13) bit positions
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_CE_LSB  = 28;
  localparam int CAUSE_DC      = 27;
  localparam int CAUSE_IV      = 23;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_EXC_LSB = 2;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Exception record captured on commit
  typedef struct packed {
    logic [4:0] exccode;
    logic       bd;
    logic [1:0] ce;
  } exc_info_t;

  // Index of the highest set bit (IP7 wins); 0 when nothing is set
  function automatic logic [2:0] ip_prio(input logic [7:0] pend);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 8; i++)
      if (pend[i]) n = 3'(i);
    return n;
  endfunction

endpackage

// File: rtl/cp0_irq_line.sv
// One hardware interrupt line: synchroniser, optional rising-edge latch, IP bit.
module cp0_irq_line #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_raw,
  input  logic clr,
  output logic ip
);

  logic irq_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = irq_raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Synchroniser chain toward the clk domain
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else begin
          sync_q[0] <= irq_raw;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign irq_s = sync_q[SYNC_STAGES-1];
    end

    if (EDGE) begin : g_edge
      logic prev_q;
      // Latch rising edges until software clears; a fresh edge beats a clear
      always_ff @(posedge clk) begin
        if (reset) begin
          prev_q <= 1'b0;
          ip     <= 1'b0;
        end else begin
          prev_q <= irq_s;
          if (irq_s & ~prev_q) ip <= 1'b1;
          else if (clr)        ip <= 1'b0;
        end
      end
    end else begin : g_level
      logic unused_clr;
      assign unused_clr = clr;
      // Level line simply follows the synchronised input
      always_ff @(posedge clk) begin
        if (reset) ip <= 1'b0;
        else       ip <= irq_s;
      end
    end
  endgenerate

endmodule

// File: rtl/cp0_cause_unit.sv
// CP0 Cause register with interrupt-pending front end and registered IRQ request.
module cp0_cause_unit
  import cp0_pkg::*;
#(
  parameter int         NUM_HW_IRQ  = 6,
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] EDGE_MASK   = 6'b000000,
  parameter int         TIMER_LINE  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_HW_IRQ-1:0] hw_irq,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  activeexception,
  input  logic [4:0]            exccode,
  input  logic                  exc_bd,
  input  logic [1:0]            exc_ce,
  input  logic [7:0]            status_im,
  input  logic                  status_ie,
  input  logic                  status_exl,
  input  logic                  status_erl,
  output logic [31:0]           cause,
  output logic                  irq_req,
  output logic [2:0]            irq_num,
  output logic                  dc
);

  logic [5:0] ip_hw;
  logic [1:0] ip_sw_q;
  logic       iv_q, dc_q;
  exc_info_t  exc_q;
  logic [7:0] ip, pend;
  logic       mtc0;
  logic       unused_wr;

  // An exception in the same cycle swallows the MTC0 completely
  assign mtc0      = wr_en & ~activeexception;
  assign unused_wr = &{1'b0, wr_data};

  generate
    for (genvar i = 0; i < 6; i++) begin : g_line
      if (i < NUM_HW_IRQ) begin : g_impl
        cp0_irq_line #(
          .SYNC_STAGES (SYNC_STAGES),
          .EDGE        (EDGE_MASK[i])
        ) u_line (
          .clk     (clk),
          .reset   (reset),
          .irq_raw (hw_irq[i]),
          .clr     (mtc0 & ~wr_data[CAUSE_IP_LSB+2+i]),
          .ip      (ip_hw[i])
        );
      end else begin : g_none
        assign ip_hw[i] = 1'b0;
      end
    end
  endgenerate

  assign ip   = {ip_hw, ip_sw_q};
  assign pend = ip & status_im;
  assign dc   = dc_q;

  // Software-writable fields and exception capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ip_sw_q <= '0;
      iv_q    <= 1'b0;
      dc_q    <= 1'b0;
      exc_q   <= '0;
    end else begin
      if (mtc0) begin
        ip_sw_q <= wr_data[CAUSE_IP_LSB +: 2];
        iv_q    <= wr_data[CAUSE_IV];
        dc_q    <= wr_data[CAUSE_DC];
      end
      if (activeexception) begin
        exc_q.exccode <= exccode;
        exc_q.bd      <= exc_bd;
        exc_q.ce      <= exc_ce;
      end
    end
  end

  // Registered, masked interrupt request and its priority index
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_req <= 1'b0;
      irq_num <= 3'd0;
    end else begin
      irq_req <= (|pend) & status_ie & ~status_exl & ~status_erl;
      irq_num <= ip_prio(pend);
    end
  end

  // Assemble the architectural register view
  always_comb begin
    cause                          = '0;
    cause[CAUSE_BD]                = exc_q.bd;
    cause[CAUSE_TI]                = ip_hw[TIMER_LINE];
    cause[CAUSE_CE_LSB +: 2]       = exc_q.ce;
    cause[CAUSE_DC]                = dc_q;
    cause[CAUSE_IV]                = iv_q;
    cause[CAUSE_IP_LSB +: 8]       = ip;
    cause[CAUSE_EXC_LSB +: 5]      = exc_q.exccode;
  end

endmodule

// File: tb/tb_cp0_cause_unit.sv
// Self-checking bench for cp0_cause_unit: vector table plus hand sequences,
// expectations queued with a due cycle and compared at the falling edge.
module tb_cp0_cause_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_irq;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        activeexception;
  logic [4:0]  exccode;
  logic        exc_bd;
  logic [1:0]  exc_ce;
  logic [7:0]  status_im;
  logic        status_ie, status_exl, status_erl;
  logic [31:0] cause;
  logic        irq_req;
  logic [2:0]  irq_num;
  logic        dc;

  cp0_cause_unit #(
    .NUM_HW_IRQ (6), .SYNC_STAGES (2), .EDGE_MASK (6'b100000), .TIMER_LINE (5)
  ) dut (
    .clk (clk), .reset (reset), .hw_irq (hw_irq), .wr_en (wr_en), .wr_data (wr_data),
    .activeexception (activeexception), .exccode (exccode), .exc_bd (exc_bd),
    .exc_ce (exc_ce), .status_im (status_im), .status_ie (status_ie),
    .status_exl (status_exl), .status_erl (status_erl), .cause (cause),
    .irq_req (irq_req), .irq_num (irq_num), .dc (dc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       name;
    logic [31:0] cause;
    logic        req;
    logic [2:0]  num;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [5:0]  hw;
    logic        wr;
    logic [31:0] wd;
    logic        exc;
    logic [4:0]  code;
    logic        bd;
    logic [1:0]  ce;
    logic [7:0]  im;
    logic        ie, exl, erl;
    int          n;
    logic [31:0] e_cause;
    logic        e_req;
    logic [2:0]  e_num;
  } vec_t;

  vec_t vecs[10];

  task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s @cyc %0d: got 0x%0h expected 0x%0h", nm, fld, cyc, act, exp);
    end
  endtask

  // Scoreboard: compare every expectation whose due cycle has arrived
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due != cyc) begin
        checks++;
        fails++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.due, cyc);
      end else begin
        cmp(e.name, "cause",   cause,          e.cause);
        cmp(e.name, "irq_req", 32'(irq_req),   32'(e.req));
        cmp(e.name, "irq_num", 32'(irq_num),   32'(e.num));
        cmp(e.name, "dc",      32'(dc),        32'(e.cause[27]));
      end
    end
  end

  task automatic expect_at(int lat, string nm, logic [31:0] c, logic r, logic [2:0] n);
    exp_t e;
    e.due = cyc + lat; e.name = nm; e.cause = c; e.req = r; e.num = n;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [31:0] BASE = 32'h2000_002C;  // CE=2, ExcCode=11 after table
  localparam logic [31:0] EDGE_SET = 32'h6000_802C; // BASE + TI + IP7

  initial begin
    reset = 1'b1; hw_irq = 6'h3F; wr_en = 1'b0; wr_data = '0;
    activeexception = 1'b0; exccode = '0; exc_bd = 1'b0; exc_ce = '0;
    status_im = '0; status_ie = 1'b0; status_exl = 1'b0; status_erl = 1'b0;

    // vector table: sequential, each row builds on the previous state
    //          hw  wr  wd            exc code  bd ce  im     ie exl erl n  cause         req num
    vecs[0] = '{6'h0, 1, 32'h0000_0200, 0, 5'd0,  0, 0, 8'h02, 1, 0, 0, 2, 32'h0000_0200, 1, 3'd1};
    vecs[1] = '{6'h0, 0, 32'h0,         0, 5'd0,  0, 0, 8'h02, 1, 1, 0, 2, 32'h0000_0200, 0, 3'd1};
    vecs[2] = '{6'h0, 1, 32'h0800_0300, 1, 5'd12, 1, 0, 8'h02, 1, 0, 0, 1, 32'h8000_0230, 1, 3'd1};
    vecs[3] = '{6'h0, 0, 32'h0,         1, 5'd11, 0, 2, 8'h02, 1, 0, 0, 1, 32'h2000_022C, 1, 3'd1};
    vecs[4] = '{6'h0, 1, 32'h0880_0100, 0, 5'd0,  0, 0, 8'h02, 1, 0, 0, 1, 32'h2880_012C, 1, 3'd1};
    vecs[5] = '{6'h0, 0, 32'h0,         0, 5'd0,  0, 0, 8'h02, 1, 0, 0, 1, 32'h2880_012C, 0, 3'd0};
    vecs[6] = '{6'h0, 0, 32'h0,         0, 5'd0,  0, 0, 8'h01, 1, 0, 0, 1, 32'h2880_012C, 1, 3'd0};
    vecs[7] = '{6'h0, 0, 32'h0,         0, 5'd0,  0, 0, 8'h01, 1, 0, 1, 1, 32'h2880_012C, 0, 3'd0};
    vecs[8] = '{6'h0, 0, 32'h0,         0, 5'd0,  0, 0, 8'h01, 0, 0, 0, 1, 32'h2880_012C, 0, 3'd0};
    vecs[9] = '{6'h0, 1, 32'h0,         0, 5'd0,  0, 0, 8'hFF, 1, 0, 0, 2, BASE,          0, 3'd0};

    // reset with every line high
    expect_at(2, "reset_hold", 32'h0, 0, 3'd0);
    expect_at(3, "reset_hold2", 32'h0, 0, 3'd0);
    step(3);
    hw_irq = 6'h1F; reset = 1'b0;
    expect_at(2, "rst_rel_early", 32'h0, 0, 3'd0);
    expect_at(3, "rst_rel_level", 32'h0000_7C00, 0, 3'd0);
    step(3);
    hw_irq = 6'h00;
    expect_at(3, "rst_rel_drop", 32'h0, 0, 3'd0);
    step(3);

    // level line 2 with IM4
    hw_irq = 6'b000100; status_im = 8'h10; status_ie = 1'b1;
    expect_at(2, "lvl_early",  32'h0,         0, 3'd0);
    expect_at(3, "lvl_ip",     32'h0000_1000, 0, 3'd0);
    expect_at(4, "lvl_req",    32'h0000_1000, 1, 3'd4);
    step(4);
    hw_irq = 6'b000000;
    expect_at(3, "lvl_drop_ip",  32'h0, 1, 3'd4);
    expect_at(4, "lvl_drop_req", 32'h0, 0, 3'd0);
    step(4);

    // table-driven section
    for (int k = 0; k < 10; k++) begin
      hw_irq = vecs[k].hw; wr_en = vecs[k].wr; wr_data = vecs[k].wd;
      activeexception = vecs[k].exc; exccode = vecs[k].code;
      exc_bd = vecs[k].bd; exc_ce = vecs[k].ce; status_im = vecs[k].im;
      status_ie = vecs[k].ie; status_exl = vecs[k].exl; status_erl = vecs[k].erl;
      expect_at(vecs[k].n, $sformatf("vec%0d", k), vecs[k].e_cause, vecs[k].e_req, vecs[k].e_num);
      step(1);
      wr_en = 1'b0; activeexception = 1'b0;
      if (vecs[k].n > 1) step(vecs[k].n - 1);
    end

    // edge line 5: one-cycle pulse latches IP7 and TI
    hw_irq = 6'b100000;
    expect_at(2, "edge_early", BASE,     0, 3'd0);
    expect_at(3, "edge_set",   EDGE_SET, 0, 3'd0);
    expect_at(4, "edge_req",   EDGE_SET, 1, 3'd7);
    expect_at(8, "edge_held",  EDGE_SET, 1, 3'd7);
    step(1);
    hw_irq = 6'b000000;
    step(7);
    wr_en = 1'b1; wr_data = 32'h0;
    expect_at(1, "edge_clr",     BASE, 1, 3'd7);
    expect_at(2, "edge_clr_req", BASE, 0, 3'd0);
    step(1);
    wr_en = 1'b0;
    step(1);

    // new edge lands in the same cycle as a clear: set wins
    hw_irq = 6'b100000;
    expect_at(3, "coinc_set", EDGE_SET, 0, 3'd0);
    step(1);
    hw_irq = 6'b000000;
    step(1);
    wr_en = 1'b1; wr_data = 32'h0;
    step(1);
    wr_en = 1'b0;
    expect_at(1, "coinc_hold",  EDGE_SET, 1, 3'd7);
    expect_at(3, "coinc_hold2", EDGE_SET, 1, 3'd7);
    step(3);
    // writing 1 to an edge bit leaves it set
    wr_en = 1'b1; wr_data = 32'h0000_8000;
    expect_at(1, "edge_w1", EDGE_SET, 1, 3'd7);
    step(1);
    wr_data = 32'h0;
    expect_at(1, "edge_clr2",     BASE, 1, 3'd7);
    expect_at(2, "edge_clr2_req", BASE, 0, 3'd0);
    step(1);
    wr_en = 1'b0;
    step(1);

    // priority: IP2, IP4, IP6 pending
    hw_irq = 6'b010101; status_im = 8'hFF;
    expect_at(3, "prio_ip",  32'h2000_542C, 0, 3'd0);
    expect_at(4, "prio_six", 32'h2000_542C, 1, 3'd6);
    step(4);
    status_im = 8'hBF;
    expect_at(1, "prio_four", 32'h2000_542C, 1, 3'd4);
    step(1);

    // reset mid-operation wins over write and exception
    reset = 1'b1; wr_en = 1'b1; wr_data = 32'hFFFF_FFFF;
    activeexception = 1'b1; exccode = 5'd12; exc_bd = 1'b1;
    expect_at(1, "mid_reset", 32'h0, 0, 3'd0);
    step(2);
    reset = 1'b0; wr_en = 1'b0; activeexception = 1'b0;

    // drain the scoreboard with a bounded wait
    for (int t = 0; t < 20 && sb.size() > 0; t++) step(1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      fails++;
      $display("FAIL %s: never compared (due %0d)", e.name, e.due);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cp0_cause_unit.md
# cp0_cause_unit

Parametrised CP0 Cause register (Reg 13) with an integrated interrupt-pending front end. It synchronises up to six hardware IRQ lines, latches edge-mode lines until software clears them, and holds the software interrupt bits IP[1:0]. It captures ExcCode/BD/CE on exceptions and generates a registered, masked interrupt request with a prioritised IRQ number. It sits in the CP0 block between the external interrupt sources, the Status register and the pipeline exception logic.

## Interface
- NUM_HW_IRQ, 6: hardware IRQ lines (1..6), mapped to IP[2+i].
- SYNC_STAGES, 2: synchroniser flops per line (0, 1 or 2; 0 means inputs are already synchronous).
- EDGE_MASK, 6'b000000: bit i=1 makes line i rising-edge latched; bit i=0 makes it level.
- TIMER_LINE, 5: hardware line reflected into TI (bit 30).

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- hw_irq  in  NUM_HW_IRQ  raw interrupt lines.
- wr_en  in  1  MTC0 to Cause.
- wr_data  in  32  MTC0 data.
- activeexception  in  1  exception commit strobe.
- exccode  in  5  exception code to record.
- exc_bd  in  1  faulting instruction is in a delay slot.
- exc_ce  in  2  coprocessor number (CpU only).
- status_im  in  8  Status.IM[7:0].
- status_ie / status_exl / status_erl  in  1 each  Status bits.
- cause  out  32  register value.
- irq_req  out  1  registered interrupt request to the pipeline.
- irq_num  out  3  index of the highest pending unmasked IP bit.
- dc  out  1  Cause.DC (Count disable).

## Operation
- Layout: BD[31], TI[30], CE[29:28], DC[27], IV[23], IP[15:8], ExcCode[6:2]. All other bits read 0.
- Hardware lines go through SYNC_STAGES flops.
- Level line: IP[2+i] equals the synchronised value each cycle.
- Edge line: a rising edge (synchronised value 1, previous value 0) sets IP[2+i], which holds until an MTC0 writes 0 to that bit. Writing 1 has no effect. A set and a clear in the same cycle: set wins.
- IP bits for unimplemented lines (i ≥ NUM_HW_IRQ) are 0.
- TI = IP[2+TIMER_LINE].
- MTC0 (wr_en, no exception): writes IP[1:0], IV and DC directly, applies edge clears, and ignores all other bits.
- Exception (activeexception): ExcCode←exccode, BD←exc_bd, CE←exc_ce. An MTC0 in the same cycle is dropped entirely. Hardware IP sampling continues.
- Request: pend = IP & status_im. irq_req ← |pend & status_ie & ~status_exl & ~status_erl. irq_num ← index of the highest set bit of pend (IP7 highest), or 0 if pend is 0.
- Reset: cause=0, dc=0, irq_req=0, irq_num=0, synchroniser and edge history cleared. Edge events in flight during reset are lost.

## Timing
- hw_irq change → IP bit updated after SYNC_STAGES+1 rising edges.
- irq_req and irq_num follow IP by 1 more cycle.
- MTC0 write visible on cause the cycle after wr_en. Software-interrupt request follows 1 cycle later.
- Exception fields visible the cycle after activeexception.
- Status mask changes affect irq_req 1 cycle later.
- Reset asserted mid-operation clears state on the next edge regardless of other inputs.

## Structure
- Shared package cp0_pkg holds:
  - Cause bit-position constants: CAUSE_BD=31, CAUSE_TI=30, CAUSE_CE_LSB=28, CAUSE_DC=27, CAUSE_IV=23, CAUSE_IP_LSB=8, CAUSE_EXC_LSB=2.
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_CPU=11, EXC_OV=12.
- One sub-module, cp0_irq_line, contains synchroniser, edge detector and pending latch. It is instantiated NUM_HW_IRQ times.

## Test plan
- Reset:
  - Assert reset with hw_irq=6'h3F → cause=0, irq_req=0, irq_num=0.
  - Release reset → level lines appear after SYNC_STAGES+1 cycles.
- Level line:
  - Line 2 high, IM=8'h10, IE=1, EXL=ERL=0 → cause[12]=1 after 3 cycles, irq_req=1 and irq_num=4 after 4 cycles.
  - Drop line 2 → both deassert on the same schedule.
- Edge line (EDGE_MASK=6'b100000):
  - 1-cycle pulse on line 5 → IP7=1, TI=1, held.
  - MTC0 with bit15=0 → cleared next cycle.
  - New edge coincident with the clear → stays set.
- Software interrupt:
  - MTC0 0x0000_0200, IM=8'h02, IE=1 → cause[9]=1 next cycle, irq_req=1 and irq_num=1 the cycle after.
  - Same with EXL=1 → irq_req stays 0.
- Exception:
  - activeexception with exccode=12, exc_bd=1, together with MTC0 0x0800_0300 → ExcCode=12, BD=1, IP[1:0] and DC unchanged.
  - Exception exccode=11, exc_ce=2 → cause[29:28]=2.
- Priority: IP2, IP4 and IP6 pending, IM=8'hFF → irq_num=6. Clear IM[6] → irq_num=4 the next cycle.
